// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//
// Contents: frame FSM state type, default divider, data width and line idle
// level. Build option: UART_TX_PARITY_EN adds a PARITY state (even parity)
// between DATA and STOP.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_DIV = 10417;  // 100 MHz / 9600 baud
  localparam int unsigned DATA_BITS       = 8;
  localparam logic        IDLE_LEVEL      = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO used as the UART transmit buffer.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   push, wdata   write request and data (ignored while full)
//   pop           read request (ignored while empty)
//   rdata         head entry, valid combinationally while not empty
//   full, empty   occupancy flags
//   level         occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO of bytes feeding an 8N1 frame generator.
//
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset (aborts frame, flushes buffer)
//   d_tx    byte to transmit, accepted when vld_tx && rdy_tx
//   vld_tx  d_tx valid this cycle
//   rdy_tx  buffer not full
//   txd     serial line, idle high, registered
//   busy    frame in progress or buffer non-empty
//   level   buffer occupancy
// Build option: UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    d_tx,
  input  logic                          vld_tx,
  output logic                          rdy_tx,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = $clog2(DATA_BITS);

  tx_state_t              state;
  tx_state_t              state_d;
  logic [CW-1:0]          cyc_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   head;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   bit_done;
  logic                   last_bit;
  logic                   line_bit;
`ifdef UART_TX_PARITY_EN
  logic                   par;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_tx),
    .wdata (d_tx),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign rdy_tx   = !full;
  assign busy     = (state != ST_IDLE) || (level != '0);
  assign bit_done = (cyc_cnt == CW'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == BW'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    line_bit = IDLE_LEVEL;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_START;
          pop     = 1'b1;
        end
      end
      ST_START: begin
        line_bit = 1'b0;
        if (bit_done) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        line_bit = shreg[0];
        if (bit_done && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        line_bit = par;
        if (bit_done) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        line_bit = 1'b1;
        // Chain straight into the next START so consecutive frames have no gap.
        if (bit_done) begin
          if (!empty) begin
            state_d = ST_START;
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // txd is registered from the current state, so the line lags the FSM by one
  // cycle; this is what puts the start bit two edges after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd     <= IDLE_LEVEL;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      txd <= line_bit;
      if (pop) begin
        shreg   <= head;
`ifdef UART_TX_PARITY_EN
        par     <= ^head;
`endif
        cyc_cnt <= '0;
        bit_cnt <= '0;
      end else if (state != ST_IDLE) begin
        if (bit_done) begin
          cyc_cnt <= '0;
          if (state == ST_DATA) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
module tb_uart_tx_buf;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] d_tx;
  logic       vld_tx;
  logic       rdy_tx;
  logic       txd;
  logic       busy;
  logic [2:0] level;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q[$];

  uart_tx_buf #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .d_tx   (d_tx),
    .vld_tx (vld_tx),
    .rdy_tx (rdy_tx),
    .txd    (txd),
    .busy   (busy),
    .level  (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit-time k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks txd every cycle for the frames queued in exp_q, skipping the first
  // 'skip' cycles that the caller has already sampled.
  task automatic expect_stream(input string tag, input int unsigned skip);
    int unsigned idx = 0;
    foreach (exp_q[f]) begin
      for (int unsigned k = 0; k < FRAME_BITS; k++) begin
        for (int unsigned c = 0; c < CLK_DIV; c++) begin
          if (idx >= skip) begin
            tick();
            check($sformatf("%s frame%0d bit%0d cyc%0d", tag, f, k, c), 32'(txd),
                  32'(frame_bit(exp_q[f], k)));
          end
          idx++;
        end
      end
    end
    exp_q.delete();
  endtask

  initial begin
    rst    = 1'b1;
    vld_tx = 1'b0;
    d_tx   = 8'h00;

    // Reset state
    tick();
    tick();
    check("rst txd", 32'(txd), 32'd1);
    check("rst level", 32'(level), 32'd0);
    check("rst rdy", 32'(rdy_tx), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("idle txd", 32'(txd), 32'd1);

    // Single byte 0xA5
    d_tx = 8'hA5; vld_tx = 1'b1;
    tick();
    vld_tx = 1'b0;
    check("single level", 32'(level), 32'd1);
    check("single txd edge1", 32'(txd), 32'd1);
    tick();
    check("single txd still high", 32'(txd), 32'd1);
    check("single busy", 32'(busy), 32'd1);
    exp_q.push_back(8'hA5);
    expect_stream("single", 0);
    check("single busy end", 32'(busy), 32'd0);
    check("single txd end", 32'(txd), 32'd1);
    tick();
    tick();

    // Back-to-back 0x00, 0xFF, 0x55
    d_tx = 8'h00; vld_tx = 1'b1;
    tick();
    d_tx = 8'hFF;
    tick();
    check("b2b txd pre", 32'(txd), 32'd1);
    d_tx = 8'h55;
    tick();
    vld_tx = 1'b0;
    check("b2b first start", 32'(txd), 32'd0);
    check("b2b level", 32'(level), 32'd2);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    expect_stream("b2b", 1);
    check("b2b busy end", 32'(busy), 32'd0);
    tick();

    // Full / drop 0x01..0x06
    d_tx = 8'h01; vld_tx = 1'b1;
    tick();
    d_tx = 8'h02;
    tick();
    check("full level after 02", 32'(level), 32'd1);
    for (int unsigned v = 3; v <= 6; v++) begin
      d_tx = 8'(v);
      tick();
      check($sformatf("full start cyc v%0d", v), 32'(txd), 32'd0);
      if (v == 3) check("full level 2", 32'(level), 32'd2);
      if (v == 4) check("full level 3", 32'(level), 32'd3);
      if (v == 5) begin
        check("full level 4", 32'(level), 32'd4);
        check("full rdy low", 32'(rdy_tx), 32'd0);
      end
      if (v == 6) begin
        check("drop level 4", 32'(level), 32'd4);
        check("drop rdy low", 32'(rdy_tx), 32'd0);
      end
    end
    vld_tx = 1'b0;
    for (int unsigned v = 1; v <= 5; v++) exp_q.push_back(8'(v));
    expect_stream("full", 4);
    check("full busy end", 32'(busy), 32'd0);
    check("full level end", 32'(level), 32'd0);
    tick();

    // Simultaneous push/pop at end of frame
    d_tx = 8'h12; vld_tx = 1'b1;
    tick();
    d_tx = 8'h34;
    tick();
    d_tx = 8'h56;
    tick();
    vld_tx = 1'b0;
    check("sim start", 32'(txd), 32'd0);
    for (int unsigned k = 1; k < 39; k++) begin
      tick();
      check($sformatf("sim frameA cyc%0d", k), 32'(txd), 32'(frame_bit(8'h12, k / CLK_DIV)));
    end
    check("sim level before", 32'(level), 32'd2);
    d_tx = 8'h78; vld_tx = 1'b1;
    tick();
    vld_tx = 1'b0;
    check("sim frameA last", 32'(txd), 32'd1);
    check("sim level push+pop", 32'(level), 32'd2);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h78);
    expect_stream("sim", 0);
    check("sim busy end", 32'(busy), 32'd0);
    tick();

    // Reset mid-frame during bit 3 of 0x3C
    d_tx = 8'h3C; vld_tx = 1'b1;
    tick();
    d_tx = 8'h11;
    tick();
    d_tx = 8'h22;
    tick();
    vld_tx = 1'b0;
    check("rstmid start", 32'(txd), 32'd0);
    for (int unsigned k = 1; k <= 17; k++) tick();
    check("rstmid bit3", 32'(txd), 32'd1);
    check("rstmid level", 32'(level), 32'd2);
    rst = 1'b1; d_tx = 8'h99; vld_tx = 1'b1;
    tick();
    rst = 1'b0; vld_tx = 1'b0;
    check("rstmid txd", 32'(txd), 32'd1);
    check("rstmid level0", 32'(level), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid rdy", 32'(rdy_tx), 32'd1);
    tick();
    tick();
    tick();
    check("rstmid quiet txd", 32'(txd), 32'd1);
    check("rstmid quiet busy", 32'(busy), 32'd0);
    d_tx = 8'h81; vld_tx = 1'b1;
    tick();
    vld_tx = 1'b0;
    tick();
    check("rstmid 81 pre", 32'(txd), 32'd1);
    exp_q.push_back(8'h81);
    expect_stream("rstmid 81", 0);
    check("rstmid 81 busy end", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
